// File: rtl/countdown_timer.sv
// Loadable down-counting timer with prescaler, one-shot or periodic expiry.
// A value is loaded over valid/ready in IDLE; expiry is a single registered pulse.
module countdown_timer #(
    parameter int COUNTER_WIDTH  = 8,
    parameter int PRESCALE_WIDTH = 4
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      clr_i,
    input  logic                      en_i,
    input  logic                      load_valid_i,
    output logic                      load_ready_o,
    input  logic [COUNTER_WIDTH-1:0]  load_val_i,
    input  logic [PRESCALE_WIDTH-1:0] load_prescale_i,
    input  logic                      periodic_i,
    output logic [COUNTER_WIDTH-1:0]  count_o,
    output logic                      busy_o,
    output logic                      expire_o
);

    typedef enum logic {IDLE, RUN} state_t;

    localparam logic [COUNTER_WIDTH-1:0]  CNT_ONE = 1;
    localparam logic [PRESCALE_WIDTH-1:0] PRE_ONE = 1;

    state_t                    state, state_nxt;
    logic [COUNTER_WIDTH-1:0]  count_nxt, reload_q, reload_nxt;
    logic [PRESCALE_WIDTH-1:0] pre_q, pre_nxt, pcnt_q, pcnt_nxt;
    logic                      periodic_q, periodic_nxt, expire_nxt;
    logic                      accept, tick;

    assign busy_o       = (state == RUN);
    assign load_ready_o = (state == IDLE);
    assign accept       = load_valid_i & load_ready_o & ~clr_i;
    assign tick         = busy_o & en_i & (pcnt_q == pre_q);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state      <= IDLE;
            count_o    <= '0;
            reload_q   <= '0;
            pre_q      <= '0;
            pcnt_q     <= '0;
            periodic_q <= 1'b0;
            expire_o   <= 1'b0;
        end else begin
            state      <= state_nxt;
            count_o    <= count_nxt;
            reload_q   <= reload_nxt;
            pre_q      <= pre_nxt;
            pcnt_q     <= pcnt_nxt;
            periodic_q <= periodic_nxt;
            expire_o   <= expire_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        count_nxt    = count_o;
        reload_nxt   = reload_q;
        pre_nxt      = pre_q;
        pcnt_nxt     = pcnt_q;
        periodic_nxt = periodic_q;
        expire_nxt   = 1'b0;
        if (clr_i) begin
            state_nxt = IDLE;
            count_nxt = '0;
            pcnt_nxt  = '0;
        end else if (accept) begin
            count_nxt    = load_val_i;
            reload_nxt   = load_val_i;
            pre_nxt      = load_prescale_i;
            periodic_nxt = periodic_i;
            pcnt_nxt     = '0;
            // A zero load expires immediately without ever entering RUN
            if (load_val_i != '0) state_nxt = RUN;
            else                  expire_nxt = 1'b1;
        end else if (busy_o && en_i) begin
            if (tick) begin
                pcnt_nxt = '0;
                if (count_o > CNT_ONE) begin
                    count_nxt = count_o - CNT_ONE;
                end else begin
                    expire_nxt = 1'b1;
                    if (periodic_q) begin
                        count_nxt = reload_q;
                    end else begin
                        count_nxt = '0;
                        state_nxt = IDLE;
                    end
                end
            end else begin
                pcnt_nxt = pcnt_q + PRE_ONE;
            end
        end
    end

endmodule

// File: tb/tb_countdown_timer.sv
// Bench for countdown_timer: directed scenarios with literal expectations plus
// randomized traffic, all checked every cycle against an elapsed-time model.
module tb_countdown_timer;

    logic       clk_i = 1'b0;
    logic       rst_i = 1'b0;
    logic       clr_i = 1'b0;
    logic       en_i = 1'b0;
    logic       load_valid_i = 1'b0;
    logic       load_ready_o;
    logic [7:0] load_val_i = '0;
    logic [3:0] load_prescale_i = '0;
    logic       periodic_i = 1'b0;
    logic [7:0] count_o;
    logic       busy_o;
    logic       expire_o;

    int n_cmp = 0;
    int n_err = 0;
    bit cmp_on = 1'b0;

    countdown_timer #(.COUNTER_WIDTH(8), .PRESCALE_WIDTH(4)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .clr_i(clr_i), .en_i(en_i),
        .load_valid_i(load_valid_i), .load_ready_o(load_ready_o),
        .load_val_i(load_val_i), .load_prescale_i(load_prescale_i),
        .periodic_i(periodic_i), .count_o(count_o), .busy_o(busy_o),
        .expire_o(expire_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a run is described by N, P, mode and the number of enabled cycles
    // elapsed since the load; the count follows from plain division.
    int m_n, m_p, m_e, m_count;
    bit m_per, m_busy, m_exp;

    always @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            m_busy = 0; m_count = 0; m_exp = 0; m_e = 0;
            m_n = 0; m_p = 0; m_per = 0;
        end else if (clr_i) begin
            m_busy = 0; m_count = 0; m_exp = 0; m_e = 0;
        end else if (!m_busy) begin
            m_exp = 0;
            if (load_valid_i) begin
                m_n = int'(load_val_i); m_p = int'(load_prescale_i);
                m_per = periodic_i; m_e = 0; m_count = m_n;
                if (m_n == 0) m_exp = 1;
                else          m_busy = 1;
            end
        end else if (en_i) begin
            m_e++;
            m_exp = 0;
            if (m_e == m_n * (m_p + 1)) begin
                m_exp = 1;
                m_e = 0;
                if (m_per) m_count = m_n;
                else begin m_count = 0; m_busy = 0; end
            end else begin
                m_count = m_n - m_e / (m_p + 1);
            end
        end else begin
            m_exp = 0;
        end
    end

    always @(negedge clk_i) begin
        if (cmp_on) begin
            chk("model_count",  int'(count_o),      m_count);
            chk("model_busy",   int'(busy_o),       int'(m_busy));
            chk("model_ready",  int'(load_ready_o), int'(!m_busy));
            chk("model_expire", int'(expire_o),     int'(m_exp));
        end
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic load(input int val, input int pre, input bit per);
        load_valid_i = 1'b1;
        load_val_i = 8'(val);
        load_prescale_i = 4'(pre);
        periodic_i = per;
        tick();
        load_valid_i = 1'b0;
    endtask

    task automatic wait_expire(input int budget, output int cyc);
        cyc = 0;
        do begin
            tick();
            cyc++;
        end while (!expire_o && cyc < budget);
    endtask

    initial begin
        int cyc;
        rst_i = 1'b1;
        #1;
        chk("reset_count", int'(count_o), 0);
        chk("reset_busy", int'(busy_o), 0);
        chk("reset_ready", int'(load_ready_o), 1);
        chk("reset_expire", int'(expire_o), 0);
        tick(); tick();
        rst_i = 1'b0;
        cmp_on = 1'b1;
        en_i = 1'b1;

        // One-shot N=5, P=0
        load(5, 0, 1'b0);
        chk("os_load_count", int'(count_o), 5);
        for (int i = 4; i >= 0; i--) begin
            tick();
            chk("os_count", int'(count_o), i);
            chk("os_expire", int'(expire_o), int'(i == 0));
        end
        chk("os_end_busy", int'(busy_o), 0);
        chk("os_end_ready", int'(load_ready_o), 1);
        tick();
        chk("os_expire_drop", int'(expire_o), 0);

        // Prescale N=2, P=3
        load(2, 3, 1'b0);
        wait_expire(50, cyc);
        chk("pre_cycles", cyc, 8);
        tick();
        load(2, 3, 1'b0);
        tick(); tick(); tick();
        en_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("gap_count", int'(count_o), 2);
        end
        en_i = 1'b1;
        wait_expire(50, cyc);
        chk("gap_cycles", cyc + 7, 12);
        tick();

        // Periodic N=3, P=0, ignored load in RUN, then clear on final tick
        load(3, 0, 1'b1);
        for (int k = 1; k <= 8; k++) begin
            if (k == 4) begin load_valid_i = 1'b1; load_val_i = 8'd9; end
            tick();
            load_valid_i = 1'b0;
            chk("per_count", int'(count_o), 3 - (k % 3));
            chk("per_expire", int'(expire_o), int'(k % 3 == 0));
            chk("per_ready", int'(load_ready_o), 0);
        end
        clr_i = 1'b1;
        tick();
        clr_i = 1'b0;
        chk("per_clr_count", int'(count_o), 0);
        chk("per_clr_busy", int'(busy_o), 0);
        chk("per_clr_expire", int'(expire_o), 0);

        // One-shot cleared on its final tick
        load(2, 0, 1'b0);
        tick();
        clr_i = 1'b1;
        tick();
        clr_i = 1'b0;
        chk("os_clr_expire", int'(expire_o), 0);
        chk("os_clr_count", int'(count_o), 0);

        // Zero load
        load(0, 2, 1'b1);
        chk("zero_expire", int'(expire_o), 1);
        chk("zero_busy", int'(busy_o), 0);
        chk("zero_count", int'(count_o), 0);
        tick();
        chk("zero_expire_drop", int'(expire_o), 0);
        chk("zero_busy_after", int'(busy_o), 0);

        // Clear with simultaneous load
        clr_i = 1'b1;
        load(6, 0, 1'b0);
        clr_i = 1'b0;
        chk("clrld_count", int'(count_o), 0);
        chk("clrld_busy", int'(busy_o), 0);

        // Asynchronous reset mid-run
        load(7, 0, 1'b0);
        chk("rst_pre_count", int'(count_o), 7);
        rst_i = 1'b1;
        #1;
        chk("rst_mid_count", int'(count_o), 0);
        chk("rst_mid_busy", int'(busy_o), 0);
        chk("rst_mid_ready", int'(load_ready_o), 1);
        chk("rst_mid_expire", int'(expire_o), 0);
        #1;
        rst_i = 1'b0;
        tick();
        chk("rst_after_expire", int'(expire_o), 0);

        // Maximum values
        load(255, 15, 1'b0);
        wait_expire(5000, cyc);
        chk("max_cycles", cyc, 4080);
        chk("max_count", int'(count_o), 0);
        tick();

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            load_valid_i = ($urandom_range(99) < 30);
            load_val_i = ($urandom_range(9) == 0) ? 8'($urandom) : 8'($urandom_range(6));
            load_prescale_i = 4'($urandom_range(3));
            periodic_i = 1'($urandom);
            en_i = ($urandom_range(99) < 80);
            clr_i = ($urandom_range(99) < 3);
            tick();
        end
        load_valid_i = 1'b0;
        clr_i = 1'b0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
